iob_cache_write_through_buffer: RTL and testbench

- Write-through buffer between the cache front-end write path and the AXI write channel.
- Queues front-end word writes (address, data, strobe) in a FIFO and holds one entry in an issue slot.
- The issue slot presents a stable address/data/strobe to the write channel from launch until the channel reports completion.
- Provides empty/full status so the cache can stall new writes and enforce read-after-write ordering.

---
 rtl/iob_cache_write_through_buffer.sv | 135 +++++++++++++
 tb/tb_iob_cache_write_through_buffer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_write_through_buffer.sv
// Write-through buffer: FIFO of front-end word writes feeding a single issue slot
// that holds address/data/strobe stable for the AXI write channel until completion.
module iob_cache_write_through_buffer #(
  parameter int unsigned ADDR_W      = 24,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned FE_NBYTES_W = $clog2(DATA_W / 8),
  parameter int unsigned DEPTH_W     = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          push_i,
  input  logic [ADDR_W-FE_NBYTES_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0]             push_wdata_i,
  input  logic [DATA_W/8-1:0]           push_wstrb_i,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH_W+1:0]            level_o,
  output logic                          overflow_o,
  output logic                          wc_valid_o,
  output logic [ADDR_W-FE_NBYTES_W-1:0] wc_addr_o,
  output logic [DATA_W-1:0]             wc_wdata_o,
  output logic [DATA_W/8-1:0]           wc_wstrb_o,
  input  logic                          wc_ready_i
);

  localparam int unsigned AW    = ADDR_W - FE_NBYTES_W;
  localparam int unsigned SW    = DATA_W / 8;
  localparam int unsigned Depth = 1 << DEPTH_W;
  localparam logic [DEPTH_W:0] FullCount = (DEPTH_W + 1)'(Depth);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e state_q, state_d;

  logic [AW-1:0]     mem_addr  [Depth];
  logic [DATA_W-1:0] mem_wdata [Depth];
  logic [SW-1:0]     mem_wstrb [Depth];

  logic [DEPTH_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [DEPTH_W:0]   count_q, count_d;
  logic               slot_valid_q, slot_valid_d;
  logic               overflow_q;
  logic [AW-1:0]      slot_addr_q;
  logic [DATA_W-1:0]  slot_wdata_q;
  logic [SW-1:0]      slot_wstrb_q;

  logic push_accept, fifo_nonempty, completion, slot_load, slot_clear, launch;

  assign full_o        = (count_q == FullCount);
  assign fifo_nonempty = (count_q != '0);
  assign push_accept   = push_i & ~full_o;
  assign completion    = (state_q == StBusy) & wc_ready_i;
  // Head moves into the slot when the slot is free or its entry just completed.
  assign slot_load     = fifo_nonempty & (~slot_valid_q | completion);

  always_comb begin
    state_d    = state_q;
    wc_valid_o = 1'b0;
    slot_clear = 1'b0;
    launch     = 1'b0;
    unique case (state_q)
      StIdle: begin
        wc_valid_o = slot_valid_q;
        launch     = slot_valid_q & wc_ready_i;
        if (launch) state_d = StBusy;
      end
      StBusy: begin
        // In BUSY, valid signals that another entry is queued behind the slot.
        wc_valid_o = slot_valid_q & fifo_nonempty;
        if (wc_ready_i && !fifo_nonempty) begin
          state_d    = StIdle;
          slot_clear = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push_accept, slot_load})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    slot_valid_d = slot_valid_q;
    if (slot_load) slot_valid_d = 1'b1;
    else if (slot_clear) slot_valid_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      slot_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      slot_wstrb_q <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      slot_valid_q <= slot_valid_d;
      if (push_i && full_o) overflow_q <= 1'b1;
      if (push_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (slot_load) begin
        rd_ptr_q     <= rd_ptr_q + 1'b1;
        slot_addr_q  <= mem_addr[rd_ptr_q];
        slot_wdata_q <= mem_wdata[rd_ptr_q];
        slot_wstrb_q <= mem_wstrb[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_accept) begin
      mem_addr[wr_ptr_q]  <= push_addr_i;
      mem_wdata[wr_ptr_q] <= push_wdata_i;
      mem_wstrb[wr_ptr_q] <= push_wstrb_i;
    end
  end

  assign overflow_o = overflow_q;
  assign empty_o    = ~fifo_nonempty & ~slot_valid_q & (state_q == StIdle);
  assign level_o    = {1'b0, count_q} + {{(DEPTH_W + 1){1'b0}}, slot_valid_q};
  assign wc_addr_o  = slot_addr_q;
  assign wc_wdata_o = slot_wdata_q;
  assign wc_wstrb_o = slot_wstrb_q;

endmodule

// File: tb/tb_iob_cache_write_through_buffer.sv
// Directed bench for iob_cache_write_through_buffer with hand-computed expectations.
module tb_iob_cache_write_through_buffer;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned FE_NBYTES_W = 2;
  localparam int unsigned DEPTH_W = 4;
  localparam int unsigned AW = ADDR_W - FE_NBYTES_W;

  logic              clk_i = 1'b0;
  logic              reset_i;
  logic              push_i;
  logic [AW-1:0]     push_addr_i;
  logic [DATA_W-1:0] push_wdata_i;
  logic [3:0]        push_wstrb_i;
  logic              full_o, empty_o, overflow_o, wc_valid_o, wc_ready_i;
  logic [DEPTH_W+1:0] level_o;
  logic [AW-1:0]     wc_addr_o;
  logic [DATA_W-1:0] wc_wdata_o;
  logic [3:0]        wc_wstrb_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  iob_cache_write_through_buffer #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FE_NBYTES_W(FE_NBYTES_W),
    .DEPTH_W    (DEPTH_W)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (push_i),
    .push_addr_i (push_addr_i),
    .push_wdata_i(push_wdata_i),
    .push_wstrb_i(push_wstrb_i),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .level_o     (level_o),
    .overflow_o  (overflow_o),
    .wc_valid_o  (wc_valid_o),
    .wc_addr_o   (wc_addr_o),
    .wc_wdata_o  (wc_wdata_o),
    .wc_wstrb_o  (wc_wstrb_o),
    .wc_ready_i  (wc_ready_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_push(input logic p, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    push_i       = p;
    push_addr_i  = a;
    push_wdata_i = d;
    push_wstrb_i = s;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
  endtask

  task automatic check_idle_empty(input string tag);
    check({tag, ".empty"}, 64'(empty_o), 64'd1);
    check({tag, ".level"}, 64'(level_o), 64'd0);
    check({tag, ".valid"}, 64'(wc_valid_o), 64'd0);
  endtask

  initial begin
    wc_ready_i = 1'b0;
    set_push(1'b0, '0, '0, '0);
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;

    // Reset state
    check_idle_empty("rst");
    check("rst.full", 64'(full_o), 64'd0);
    check("rst.ovf", 64'(overflow_o), 64'd0);
    check("rst.addr", 64'(wc_addr_o), 64'd0);
    check("rst.data", 64'(wc_wdata_o), 64'd0);
    check("rst.strb", 64'(wc_wstrb_o), 64'd0);

    // Single push, 2-cycle latency, launch then completion
    set_push(1'b1, 22'h123, 32'hDEADBEEF, 4'hF);
    step();
    set_push(1'b0, '0, '0, '0);
    check("t1.valid_n1", 64'(wc_valid_o), 64'd0);
    check("t1.level_n1", 64'(level_o), 64'd1);
    check("t1.empty_n1", 64'(empty_o), 64'd0);
    step();
    check("t1.valid_n2", 64'(wc_valid_o), 64'd1);
    check("t1.addr", 64'(wc_addr_o), 64'h123);
    check("t1.data", 64'(wc_wdata_o), 64'hDEADBEEF);
    check("t1.strb", 64'(wc_wstrb_o), 64'hF);
    wc_ready_i = 1'b1;
    step();
    wc_ready_i = 1'b0;
    check("t1.busy_valid", 64'(wc_valid_o), 64'd0);
    check("t1.busy_empty", 64'(empty_o), 64'd0);
    step();
    step();
    check("t1.busy_addr", 64'(wc_addr_o), 64'h123);
    check("t1.busy_data", 64'(wc_wdata_o), 64'hDEADBEEF);
    wc_ready_i = 1'b1;
    step();
    wc_ready_i = 1'b0;
    check_idle_empty("t1.done");

    // Three back-to-back pushes, 4-cycle turnaround
    set_push(1'b1, 22'h00A, 32'hAAAA0001, 4'h1);
    step();
    set_push(1'b1, 22'h00B, 32'hBBBB0002, 4'h3);
    step();
    set_push(1'b1, 22'h00C, 32'hCCCC0003, 4'h7);
    step();
    set_push(1'b0, '0, '0, '0);
    check("t2.addrA", 64'(wc_addr_o), 64'h00A);
    check("t2.level3", 64'(level_o), 64'd3);
    check("t2.validA", 64'(wc_valid_o), 64'd1);
    wc_ready_i = 1'b1;
    step();
    wc_ready_i = 1'b0;
    check("t2.busy_valid", 64'(wc_valid_o), 64'd1);
    repeat (3) step();
    wc_ready_i = 1'b1;
    step();
    wc_ready_i = 1'b0;
    check("t2.addrB", 64'(wc_addr_o), 64'h00B);
    check("t2.dataB", 64'(wc_wdata_o), 64'hBBBB0002);
    check("t2.level2", 64'(level_o), 64'd2);
    repeat (3) step();
    wc_ready_i = 1'b1;
    step();
    wc_ready_i = 1'b0;
    check("t2.addrC", 64'(wc_addr_o), 64'h00C);
    check("t2.strbC", 64'(wc_wstrb_o), 64'h7);
    check("t2.validC", 64'(wc_valid_o), 64'd0);
    check("t2.emptyC", 64'(empty_o), 64'd0);
    repeat (3) step();
    wc_ready_i = 1'b1;
    step();
    wc_ready_i = 1'b0;
    check_idle_empty("t2.done");

    // Later push after returning to IDLE restarts with 2-cycle latency
    set_push(1'b1, 22'h0D0, 32'h0000D00D, 4'h8);
    step();
    set_push(1'b0, '0, '0, '0);
    check("t5.valid_n1", 64'(wc_valid_o), 64'd0);
    step();
    check("t5.valid_n2", 64'(wc_valid_o), 64'd1);
    check("t5.addr", 64'(wc_addr_o), 64'h0D0);
    wc_ready_i = 1'b1;
    step();
    step();
    wc_ready_i = 1'b0;
    check_idle_empty("t5.done");

    // Fill 16 + slot with the channel stalled, then overflow, then drain in order
    for (int i = 0; i < 17; i++) begin
      set_push(1'b1, AW'(32'h100 + i), 32'hA5000000 + i, 4'(i));
      step();
    end
    check("t3.full", 64'(full_o), 64'd1);
    check("t3.level17", 64'(level_o), 64'd17);
    check("t3.ovf0", 64'(overflow_o), 64'd0);
    set_push(1'b1, 22'h3FF, 32'hBAD0BAD0, 4'hF);
    step();
    set_push(1'b0, '0, '0, '0);
    check("t3.ovf1", 64'(overflow_o), 64'd1);
    check("t3.level_drop", 64'(level_o), 64'd17);
    check("t3.addr0", 64'(wc_addr_o), 64'h100);
    wc_ready_i = 1'b1;
    step();
    for (int i = 0; i < 17; i++) begin
      check($sformatf("t3.drain_addr%0d", i), 64'(wc_addr_o), 64'(32'h100 + i));
      check($sformatf("t3.drain_data%0d", i), 64'(wc_wdata_o), 64'(32'hA5000000 + i));
      check($sformatf("t3.drain_strb%0d", i), 64'(wc_wstrb_o), 64'(i % 16));
      step();
    end
    wc_ready_i = 1'b0;
    check_idle_empty("t3.done");
    check("t3.ovf_sticky", 64'(overflow_o), 64'd1);
    check("t3.full0", 64'(full_o), 64'd0);

    // Push coinciding with slot load at count=5
    do_reset();
    check("t4.ovf_rst", 64'(overflow_o), 64'd0);
    for (int i = 0; i < 6; i++) begin
      set_push(1'b1, AW'(32'h200 + i), 32'hC0000000 + i, 4'hF);
      step();
    end
    set_push(1'b0, '0, '0, '0);
    check("t4.level6", 64'(level_o), 64'd6);
    wc_ready_i = 1'b1;
    step();
    check("t4.addr0", 64'(wc_addr_o), 64'h200);
    set_push(1'b1, 22'h206, 32'hC0000006, 4'hF);
    step();
    set_push(1'b0, '0, '0, '0);
    wc_ready_i = 1'b0;
    check("t4.level_same", 64'(level_o), 64'd6);
    check("t4.addr1", 64'(wc_addr_o), 64'h201);

    // Reset while BUSY with count=7
    set_push(1'b1, 22'h207, 32'hC0000007, 4'hF);
    step();
    set_push(1'b1, 22'h208, 32'hC0000008, 4'hF);
    step();
    set_push(1'b0, '0, '0, '0);
    check("t6.level8", 64'(level_o), 64'd8);
    do_reset();
    check_idle_empty("t6.rst");
    check("t6.ovf", 64'(overflow_o), 64'd0);
    check("t6.addr", 64'(wc_addr_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
